// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// mem_access_ctrl
//   Memory-stage controller that sits in front of the load byte/half extractor.
//   It accepts one load or store per handshake and issues a word-aligned
//   request to the data cache. For stores it generates the byte mask and the
//   lane-aligned data. For loads it waits for the cache word, then presents
//   word + offset + funct3 + rd to the extractor for one cycle. The pipeline
//   is stalled whenever the controller is not idle.
//
//   Optional build macro MISALIGN_TRAP_EN:
//     Misaligned halfword (offset 3) and word (offset != 0) accesses are
//     accepted but never issued. A one-cycle 'misalign' pulse follows the
//     acceptance instead. Without the macro there is no misalign port, and
//     misaligned accesses are issued using the normal lane rules.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid / req_ready         pipeline op handshake (ready only when idle)
//   req_is_load / req_is_store    op kind (load wins if both are set)
//   req_addr, req_wdata           byte address, unshifted store data (rs2)
//   req_funct3, req_rd            RV32 funct3, load destination register
//   dc_req_valid / dc_req_ready   cache request handshake
//   dc_addr, dc_we                word-aligned address, write enable
//   dc_wmask, dc_wdata            byte-lane enables, lane-aligned store data
//   dc_resp_valid, dc_resp_data   cache load response
//   ld_valid                      one-cycle pulse: load result is valid
//   ld_mem_output, ld_offset      registered cache word, addr[1:0] of the load
//   ld_funct3, ld_rd              funct3 and rd of the load
//   stall                         high whenever the controller is not idle
//   misalign                      (MISALIGN_TRAP_EN only) misaligned op pulse
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic [ADDR_W-1:0] dc_addr,
  output logic              dc_we,
  output logic [3:0]        dc_wmask,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_data,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_mem_output,
  output logic [1:0]        ld_offset,
  output logic [2:0]        ld_funct3,
  output logic [4:0]        ld_rd,
  output logic              stall
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        wmask_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;

  logic [1:0]        off;
  logic              size_b;
  logic              size_h;
  logic [3:0]        st_mask;
  logic [DATA_W-1:0] st_data;
  logic              accept;
  logic              issue;

  assign off    = req_addr[1:0];
  assign accept = (state == IDLE) && req_valid && (req_is_load || req_is_store);

  // Access size. Loads use funct3[1:0] so LBU/LHU size like LB/LH; any
  // encoding that is not byte or half is handled as a word.
  always_comb begin
    size_b = 1'b0;
    size_h = 1'b0;
    if (req_is_load) begin
      size_b = (req_funct3[1:0] == 2'b00);
      size_h = (req_funct3[1:0] == 2'b01);
    end else begin
      size_b = (req_funct3 == 3'b000);
      size_h = (req_funct3 == 3'b001);
    end
  end

  always_comb begin
    st_mask = 4'b1111;
    st_data = req_wdata;
    if (size_b) begin
      st_mask = 4'b0001 << off;
      st_data = {4{req_wdata[7:0]}};
    end else if (size_h) begin
      case (off)
        2'b00: begin
          st_mask = 4'b0011;
          st_data = {16'h0000, req_wdata[15:0]};
        end
        2'b01: begin
          st_mask = 4'b0110;
          st_data = {8'h00, req_wdata[15:0], 8'h00};
        end
        default: begin
          st_mask = 4'b1100;
          st_data = {req_wdata[15:0], 16'h0000};
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned = (size_h && (off == 2'b11)) ||
                      (!size_b && !size_h && (off != 2'b00));
  assign issue      = accept && !misaligned;
  assign misalign   = misalign_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && misaligned;
    end
  end
`else
  assign issue = accept;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue)         state_next = REQ;
      REQ:  if (dc_req_ready)  state_next = we_q ? IDLE : WAIT;
      WAIT: if (dc_resp_valid) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Request fields are captured at acceptance so they stay stable for the
  // whole REQ phase regardless of what the pipeline drives meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
    end else if (issue) begin
      addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
      we_q     <= !req_is_load;
      wmask_q  <= req_is_load ? 4'b0000 : st_mask;
      wdata_q  <= req_is_load ? '0 : st_data;
      off_q    <= off;
      funct3_q <= req_funct3;
      rd_q     <= req_rd;
    end
  end

  // Extractor-facing fields only change when a load completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_mem_output <= '0;
      ld_offset     <= '0;
      ld_funct3     <= '0;
      ld_rd         <= '0;
    end else if ((state == WAIT) && dc_resp_valid) begin
      ld_mem_output <= dc_resp_data;
      ld_offset     <= off_q;
      ld_funct3     <= funct3_q;
      ld_rd         <= rd_q;
    end
  end

  assign req_ready    = (state == IDLE);
  assign stall        = (state != IDLE);
  assign dc_req_valid = (state == REQ);
  assign ld_valid     = (state == DONE);
  assign dc_addr      = addr_q;
  assign dc_we        = we_q;
  assign dc_wmask     = wmask_q;
  assign dc_wdata     = wdata_q;

endmodule
